// File: rtl/store_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_queue_pkg
//  Description : Shared types and constants for the LSQ store queue.
//                Provides the entry state enum, the entry record, the FU fill
//                and load-lookup packets, and the memory access size type.
//                SQ_IDX_LEN is taken from `LSQ_IDX_LEN. SQ_DEPTH is derived
//                from it and is always a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef LSQ_IDX_LEN
`define LSQ_IDX_LEN 3
`endif

package store_queue_pkg;

    localparam int XLEN       = 32;
    localparam int SQ_IDX_LEN = `LSQ_IDX_LEN;
    localparam int SQ_DEPTH   = 1 << SQ_IDX_LEN;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } MEM_SIZE;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        ALLOC     = 2'd1,
        READY     = 2'd2,
        COMMITTED = 2'd3
    } SQ_ENTRY_STATE;

    typedef struct packed {
        SQ_ENTRY_STATE   state;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        MEM_SIZE         size;
    } SQ_ENTRY;

    typedef struct packed {
        logic                  valid;
        logic                  store;
        logic [SQ_IDX_LEN-1:0] sq_pos;
        logic [XLEN-1:0]       addr;
        logic [XLEN-1:0]       value;
        MEM_SIZE               mem_size;
    } FU_SQ_PACKET;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       addr;
        MEM_SIZE               mem_size;
        logic [SQ_IDX_LEN-1:0] sq_pos;
    } SQ_LOAD_LOOKUP;

    // Byte count of an access (1, 2 or 4).
    function automatic logic [2:0] mem_size_bytes(input MEM_SIZE s);
        case (s)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/store_queue_fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : sq_fwd_select
//  Description : Store-to-load lookup for the store queue. Scans entries
//                older than the load (head up to ld sq_pos, exclusive).
//                Selects the youngest overlapping READY/COMMITTED store and
//                decides between hit, stall and no-match.
//                With STORE_FWD_EN defined, fully covering stores forward
//                their data, and partial overlap stalls. Without it, any
//                overlap stalls, and hit/value are tied to zero.
//  Ports       : i_entries  - full entry array
//                i_head     - oldest entry index
//                i_load     - load lookup packet (valid, addr, size, sq_pos)
//                o_hit      - load fully satisfied by an older store
//                o_stall    - load must wait
//                o_value    - forwarded data, LSB-aligned, zero-extended
//  Revision    : 1.0 - initial release
// ============================================================================

module sq_fwd_select
    import store_queue_pkg::*;
(
    input  SQ_ENTRY [SQ_DEPTH-1:0] i_entries,
    input  logic [SQ_IDX_LEN-1:0]  i_head,
    input  SQ_LOAD_LOOKUP          i_load,
    output logic                   o_hit,
    output logic                   o_stall,
    output logic [XLEN-1:0]        o_value
);

    // The 33-bit arithmetic keeps addr+size from wrapping at the top of the
    // address space.
    function automatic logic overlaps(input logic [XLEN-1:0] a, input MEM_SIZE sa,
                                      input logic [XLEN-1:0] b, input MEM_SIZE sb);
        logic [XLEN:0] a_lo, a_hi, b_lo, b_hi;
        a_lo = {1'b0, a};
        b_lo = {1'b0, b};
        a_hi = a_lo + (XLEN+1)'(mem_size_bytes(sa));
        b_hi = b_lo + (XLEN+1)'(mem_size_bytes(sb));
        return (a_lo < b_hi) && (b_lo < a_hi);
    endfunction

    logic [SQ_IDX_LEN-1:0] w_dist;
    logic [SQ_IDX_LEN-1:0] w_idx;
    logic [SQ_IDX_LEN-1:0] w_sel;
    logic                  w_any_alloc;
    logic                  w_found;

    // Entries are visited oldest to youngest. A later match overwrites an
    // earlier one, so the surviving w_sel is the youngest overlapping store.
    // When ld sq_pos equals head, the older-entry window is empty.
    always_comb begin
        w_dist      = i_load.sq_pos - i_head;
        w_idx       = '0;
        w_sel       = '0;
        w_any_alloc = 1'b0;
        w_found     = 1'b0;
        for (int k = 0; k < SQ_DEPTH; k++) begin
            w_idx = i_head + SQ_IDX_LEN'(k);
            if (SQ_IDX_LEN'(k) < w_dist) begin
                if (i_entries[w_idx].state == ALLOC) begin
                    w_any_alloc = 1'b1;
                end else if ((i_entries[w_idx].state == READY ||
                              i_entries[w_idx].state == COMMITTED) &&
                             overlaps(i_entries[w_idx].addr, i_entries[w_idx].size,
                                      i_load.addr, i_load.mem_size)) begin
                    w_found = 1'b1;
                    w_sel   = w_idx;
                end
            end
        end
    end

`ifdef STORE_FWD_EN
    SQ_ENTRY         w_st;
    logic [XLEN:0]   w_st_hi;
    logic [XLEN:0]   w_ld_hi;
    logic            w_cover;
    logic [1:0]      w_shift;
    logic [XLEN-1:0] w_shifted;

    always_comb begin
        w_st      = i_entries[w_sel];
        w_st_hi   = {1'b0, w_st.addr} + (XLEN+1)'(mem_size_bytes(w_st.size));
        w_ld_hi   = {1'b0, i_load.addr} + (XLEN+1)'(mem_size_bytes(i_load.mem_size));
        w_cover   = (w_st.addr <= i_load.addr) && (w_ld_hi <= w_st_hi);
        // A covering store is at most 3 bytes below the load, so the
        // low-bit difference is the full byte offset.
        w_shift   = i_load.addr[1:0] - w_st.addr[1:0];
        w_shifted = w_st.data >> {w_shift, 3'b000};
        o_stall   = i_load.valid && (w_any_alloc || (w_found && !w_cover));
        o_hit     = i_load.valid && !w_any_alloc && w_found && w_cover;
        o_value   = '0;
        if (o_hit) begin
            case (i_load.mem_size)
                BYTE:    o_value = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
                HALF:    o_value = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
                default: o_value = w_shifted;
            endcase
        end
    end
`else
    // The store data is not needed when forwarding is disabled.
    logic w_unused_data;
    always_comb begin
        w_unused_data = 1'b0;
        for (int k = 0; k < SQ_DEPTH; k++) begin
            w_unused_data = w_unused_data ^ (^i_entries[k].data);
        end
        w_unused_data = w_unused_data ^ (^w_sel);
        o_stall = i_load.valid && (w_any_alloc || w_found);
        o_hit   = 1'b0;
        o_value = '0;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/store_queue.sv
`default_nettype none
// ============================================================================
//  Module      : store_queue
//  Description : Circular LSQ store queue. Allocates at dispatch, captures
//                address/data at FU execute, and marks entries committed as
//                the ROB retires stores. Committed entries drain in order to
//                the data cache, and the queue answers load lookups
//                (forward or stall).
//                Optional feature macro: STORE_FWD_EN (enables data forwarding).
//  Ports       : i_clk, i_rst_n (async, active-low)
//                dispatch : i_dispatch_en -> o_sq_tail, o_sq_full
//                FU fill  : i_fu_valid, i_fu_store, i_fu_sq_pos, i_fu_addr,
//                           i_fu_value, i_fu_mem_size
//                lookup   : i_ld_valid, i_ld_addr, i_ld_mem_size, i_ld_sq_pos
//                           -> o_fwd_hit, o_fwd_value, o_fwd_stall
//                retire   : i_rt_store, i_squash
//                drain    : o_mem_req, o_mem_addr, o_mem_data, o_mem_size,
//                           i_mem_ack
//  Revision    : 1.0 - initial release
// ============================================================================

module store_queue
    import store_queue_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_dispatch_en,
    output logic [SQ_IDX_LEN-1:0] o_sq_tail,
    output logic                  o_sq_full,
    input  logic                  i_fu_valid,
    input  logic                  i_fu_store,
    input  logic [SQ_IDX_LEN-1:0] i_fu_sq_pos,
    input  logic [XLEN-1:0]       i_fu_addr,
    input  logic [XLEN-1:0]       i_fu_value,
    input  MEM_SIZE               i_fu_mem_size,
    input  logic                  i_ld_valid,
    input  logic [XLEN-1:0]       i_ld_addr,
    input  MEM_SIZE               i_ld_mem_size,
    input  logic [SQ_IDX_LEN-1:0] i_ld_sq_pos,
    output logic                  o_fwd_hit,
    output logic [XLEN-1:0]       o_fwd_value,
    output logic                  o_fwd_stall,
    input  logic                  i_rt_store,
    input  logic                  i_squash,
    output logic                  o_mem_req,
    output logic [XLEN-1:0]       o_mem_addr,
    output logic [XLEN-1:0]       o_mem_data,
    output MEM_SIZE               o_mem_size,
    input  logic                  i_mem_ack
);

    localparam logic [SQ_IDX_LEN:0] C_FULL_COUNT = (SQ_IDX_LEN+1)'(SQ_DEPTH);

    SQ_ENTRY [SQ_DEPTH-1:0] r_entries;
    logic [SQ_IDX_LEN-1:0]  r_head;
    logic [SQ_IDX_LEN-1:0]  r_commit_ptr;
    logic [SQ_IDX_LEN-1:0]  r_tail;
    logic [SQ_IDX_LEN:0]    r_count;
    logic                   r_mem_req;
    logic [XLEN-1:0]        r_mem_addr;
    logic [XLEN-1:0]        r_mem_data;
    MEM_SIZE                r_mem_size;

    SQ_ENTRY [SQ_DEPTH-1:0] w_entries_n;
    logic [SQ_IDX_LEN-1:0]  w_head_n;
    logic [SQ_IDX_LEN-1:0]  w_commit_n;
    logic [SQ_IDX_LEN-1:0]  w_tail_n;
    logic [SQ_IDX_LEN:0]    w_count_n;
    logic                   w_full;
    logic                   w_drain;
    logic                   w_dispatch;
    logic                   w_fill;
    logic                   w_commit;
    FU_SQ_PACKET            w_fu;
    SQ_LOAD_LOOKUP          w_load;

    always_comb begin
        w_fu.valid      = i_fu_valid;
        w_fu.store      = i_fu_store;
        w_fu.sq_pos     = i_fu_sq_pos;
        w_fu.addr       = i_fu_addr;
        w_fu.value      = i_fu_value;
        w_fu.mem_size   = i_fu_mem_size;
        w_load.valid    = i_ld_valid;
        w_load.addr     = i_ld_addr;
        w_load.mem_size = i_ld_mem_size;
        w_load.sq_pos   = i_ld_sq_pos;
    end

    assign w_full    = (r_count == C_FULL_COUNT);
    assign o_sq_full = w_full;
    assign o_sq_tail = r_tail;

    // Next-state: drain first, then dispatch/fill/commit, then squash
    // overrides everything except the drain handshake.
    always_comb begin
        w_entries_n = r_entries;
        w_head_n    = r_head;
        w_commit_n  = r_commit_ptr;
        w_tail_n    = r_tail;
        w_count_n   = r_count;

        w_drain    = r_mem_req && i_mem_ack;
        w_dispatch = i_dispatch_en && !w_full && !i_squash;
        w_fill     = w_fu.valid && w_fu.store && !i_squash &&
                     (r_entries[w_fu.sq_pos].state == ALLOC);
        w_commit   = i_rt_store && !i_squash &&
                     (r_entries[r_commit_ptr].state == READY);

        if (w_drain) begin
            w_entries_n[r_head] = '0;
            w_head_n            = r_head + 1'b1;
        end
        if (w_fill) begin
            w_entries_n[w_fu.sq_pos].state = READY;
            w_entries_n[w_fu.sq_pos].addr  = w_fu.addr;
            w_entries_n[w_fu.sq_pos].data  = w_fu.value;
            w_entries_n[w_fu.sq_pos].size  = w_fu.mem_size;
        end
        if (w_commit) begin
            w_entries_n[r_commit_ptr].state = COMMITTED;
            w_commit_n                      = r_commit_ptr + 1'b1;
        end
        if (w_dispatch) begin
            w_entries_n[r_tail].state = ALLOC;
            w_tail_n                  = r_tail + 1'b1;
        end

        if (i_squash) begin
            w_tail_n  = r_commit_ptr;
            w_count_n = '0;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                if (w_entries_n[i].state != COMMITTED) begin
                    w_entries_n[i] = '0;
                end else begin
                    w_count_n = w_count_n + 1'b1;
                end
            end
        end else if (w_dispatch && !w_drain) begin
            w_count_n = r_count + 1'b1;
        end else if (w_drain && !w_dispatch) begin
            w_count_n = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_entries    <= '0;
            r_head       <= '0;
            r_commit_ptr <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_size   <= BYTE;
        end else begin
            r_entries    <= w_entries_n;
            r_head       <= w_head_n;
            r_commit_ptr <= w_commit_n;
            r_tail       <= w_tail_n;
            r_count      <= w_count_n;
            // The drain port presents the post-update head. A committed head
            // cannot change until acked, so the fields hold steady while
            // the request is pending.
            if (w_entries_n[w_head_n].state == COMMITTED) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= w_entries_n[w_head_n].addr;
                r_mem_data <= w_entries_n[w_head_n].data;
                r_mem_size <= w_entries_n[w_head_n].size;
            end else begin
                r_mem_req  <= 1'b0;
                r_mem_addr <= '0;
                r_mem_data <= '0;
                r_mem_size <= BYTE;
            end
        end
    end

    assign o_mem_req  = r_mem_req;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_data = r_mem_data;
    assign o_mem_size = r_mem_size;

    sq_fwd_select u_fwd_select (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_load    (w_load),
        .o_hit     (o_fwd_hit),
        .o_stall   (o_fwd_stall),
        .o_value   (o_fwd_value)
    );

endmodule

`default_nettype wire

// File: tb/tb_store_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_queue
//  Description : Directed self-checking bench for store_queue. Covers
//                reset, fill to full, drain ordering, async reset mid-drain,
//                forwarding/stall lookups, and commit followed by squash.
//                Expected lookup results follow STORE_FWD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_store_queue;
    import store_queue_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            dispatch_en = 1'b0;
    logic [2:0]      sq_tail;
    logic            sq_full;
    logic            fu_valid = 1'b0;
    logic            fu_store = 1'b0;
    logic [2:0]      fu_sq_pos = '0;
    logic [31:0]     fu_addr = '0;
    logic [31:0]     fu_value = '0;
    MEM_SIZE         fu_mem_size = BYTE;
    logic            ld_valid = 1'b0;
    logic [31:0]     ld_addr = '0;
    MEM_SIZE         ld_mem_size = BYTE;
    logic [2:0]      ld_sq_pos = '0;
    logic            fwd_hit;
    logic [31:0]     fwd_value;
    logic            fwd_stall;
    logic            rt_store = 1'b0;
    logic            squash = 1'b0;
    logic            mem_req;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_data;
    MEM_SIZE         mem_size;
    logic            mem_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    store_queue dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_dispatch_en (dispatch_en),
        .o_sq_tail     (sq_tail),
        .o_sq_full     (sq_full),
        .i_fu_valid    (fu_valid),
        .i_fu_store    (fu_store),
        .i_fu_sq_pos   (fu_sq_pos),
        .i_fu_addr     (fu_addr),
        .i_fu_value    (fu_value),
        .i_fu_mem_size (fu_mem_size),
        .i_ld_valid    (ld_valid),
        .i_ld_addr     (ld_addr),
        .i_ld_mem_size (ld_mem_size),
        .i_ld_sq_pos   (ld_sq_pos),
        .o_fwd_hit     (fwd_hit),
        .o_fwd_value   (fwd_value),
        .o_fwd_stall   (fwd_stall),
        .i_rt_store    (rt_store),
        .i_squash      (squash),
        .o_mem_req     (mem_req),
        .o_mem_addr    (mem_addr),
        .o_mem_data    (mem_data),
        .o_mem_size    (mem_size),
        .i_mem_ack     (mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch();
        dispatch_en = 1'b1;
        tick();
        dispatch_en = 1'b0;
    endtask

    task automatic fill(input logic [2:0] pos, input logic [31:0] a,
                        input logic [31:0] v, input MEM_SIZE sz);
        fu_valid = 1'b1; fu_store = 1'b1; fu_sq_pos = pos;
        fu_addr = a; fu_value = v; fu_mem_size = sz;
        tick();
        fu_valid = 1'b0; fu_store = 1'b0;
    endtask

    task automatic commit();
        rt_store = 1'b1;
        tick();
        rt_store = 1'b0;
    endtask

    // eh/ev/es are the forwarding-build expectations; without forwarding
    // any hit or stall case becomes a plain stall.
    task automatic lookup(input string tag, input logic [31:0] a, input MEM_SIZE sz,
                          input logic [2:0] pos, input logic eh,
                          input logic [31:0] ev, input logic es);
        ld_valid = 1'b1; ld_addr = a; ld_mem_size = sz; ld_sq_pos = pos;
        #1;
`ifdef STORE_FWD_EN
        chk({tag, ".hit"},   32'(fwd_hit),   32'(eh));
        chk({tag, ".value"}, fwd_value,      ev);
        chk({tag, ".stall"}, 32'(fwd_stall), 32'(es));
`else
        chk({tag, ".hit"},   32'(fwd_hit),   32'd0);
        chk({tag, ".value"}, fwd_value,      32'd0);
        chk({tag, ".stall"}, 32'(fwd_stall), 32'(eh | es));
        if (ev == 32'hFFFF_FFFF) $display("unreachable value marker");
`endif
        ld_valid = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #12;
        chk("rst.tail", 32'(sq_tail), 32'd0);
        chk("rst.full", 32'(sq_full), 32'd0);
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_size", 32'(mem_size), 32'(BYTE));
        chk("rst.fwd_stall", 32'(fwd_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- fill to full ----------------
        for (int i = 0; i < 8; i++) begin
            dispatch();
            chk($sformatf("disp%0d.tail", i), 32'(sq_tail), 32'((i + 1) % 8));
            if (i == 6) chk("disp6.full", 32'(sq_full), 32'd0);
        end
        chk("full.full", 32'(sq_full), 32'd1);
        dispatch();
        chk("disp_ovf.tail", 32'(sq_tail), 32'd0);
        chk("disp_ovf.full", 32'(sq_full), 32'd1);

        for (int i = 0; i < 8; i++) begin
            fill(3'(i), 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), WORD);
        end
        chk("filled.mem_req", 32'(mem_req), 32'd0);
        commit();
        chk("c0.mem_req", 32'(mem_req), 32'd1);
        chk("c0.mem_addr", mem_addr, 32'h1000);
        for (int i = 1; i < 8; i++) commit();
        tick();
        chk("hold.mem_addr", mem_addr, 32'h1000);
        chk("hold.mem_data", mem_data, 32'hA000_0000);
        chk("hold.mem_size", 32'(mem_size), 32'(WORD));

        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("ack0.full", 32'(sq_full), 32'd0);
        chk("ack0.mem_req", 32'(mem_req), 32'd1);
        chk("ack0.mem_addr", mem_addr, 32'h1004);

        // Dispatch together with a drain keeps the count at 7.
        mem_ack = 1'b1; dispatch_en = 1'b1;
        tick();
        mem_ack = 1'b0; dispatch_en = 1'b0;
        chk("ackdisp.full", 32'(sq_full), 32'd0);
        chk("ackdisp.tail", 32'(sq_tail), 32'd1);
        chk("ackdisp.mem_addr", mem_addr, 32'h1008);
        dispatch();
        chk("refull.full", 32'(sq_full), 32'd1);
        chk("refull.tail", 32'(sq_tail), 32'd2);

        // ---------------- asynchronous reset mid-drain ----------------
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.mem_req", 32'(mem_req), 32'd0);
        chk("arst.tail", 32'(sq_tail), 32'd0);
        chk("arst.full", 32'(sq_full), 32'd0);
        chk("arst.mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- forwarding ----------------
        dispatch();
        fill(3'd0, 32'h100, 32'hDEAD_BEEF, WORD);
        ld_valid = 1'b0; ld_addr = 32'h102; ld_mem_size = BYTE; ld_sq_pos = 3'd1;
        #1;
        chk("ldoff.hit", 32'(fwd_hit), 32'd0);
        chk("ldoff.stall", 32'(fwd_stall), 32'd0);
        chk("ldoff.value", fwd_value, 32'd0);
        lookup("lb102", 32'h102, BYTE, 3'd1, 1'b1, 32'h0000_00AD, 1'b0);
        lookup("lh102", 32'h102, HALF, 3'd1, 1'b1, 32'h0000_DEAD, 1'b0);
        lookup("lw100", 32'h100, WORD, 3'd1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        lookup("lw102", 32'h102, WORD, 3'd1, 1'b0, 32'd0, 1'b1);
        lookup("lb102_young", 32'h102, BYTE, 3'd0, 1'b0, 32'd0, 1'b0);

        // Older entry still ALLOC stalls an unrelated load.
        dispatch();
        lookup("alloc_stall", 32'h300, BYTE, 3'd2, 1'b0, 32'd0, 1'b1);
        fill(3'd1, 32'h200, 32'h0000_0055, BYTE);
        lookup("after_fill", 32'h300, BYTE, 3'd2, 1'b0, 32'd0, 1'b0);
        lookup("lb200", 32'h200, BYTE, 3'd2, 1'b1, 32'h0000_0055, 1'b0);

        // Youngest overlapping store decides.
        dispatch();
        fill(3'd2, 32'h100, 32'h0000_0011, BYTE);
        lookup("partial", 32'h100, WORD, 3'd3, 1'b0, 32'd0, 1'b1);
        lookup("young_b100", 32'h100, BYTE, 3'd3, 1'b1, 32'h0000_0011, 1'b0);
        lookup("old_b101", 32'h101, BYTE, 3'd3, 1'b1, 32'h0000_00BE, 1'b0);

        // ---------------- commit two of four, then squash ----------------
        dispatch();
        fill(3'd3, 32'h400, 32'h1234_5678, WORD);
        commit();
        commit();
        chk("cm.mem_req", 32'(mem_req), 32'd1);
        chk("cm.mem_addr", mem_addr, 32'h100);
        chk("cm.mem_data", mem_data, 32'hDEAD_BEEF);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        chk("sq.tail", 32'(sq_tail), 32'd2);
        chk("sq.full", 32'(sq_full), 32'd0);
        lookup("sq_gone", 32'h400, BYTE, 3'd4, 1'b0, 32'd0, 1'b0);
        lookup("sq_kept", 32'h200, BYTE, 3'd2, 1'b1, 32'h0000_0055, 1'b0);
        tick();
        chk("sqhold.mem_addr", mem_addr, 32'h100);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("dr1.mem_req", 32'(mem_req), 32'd1);
        chk("dr1.mem_addr", mem_addr, 32'h200);
        chk("dr1.mem_data", mem_data, 32'h0000_0055);
        chk("dr1.mem_size", 32'(mem_size), 32'(BYTE));
        tick();
        chk("dr1hold.mem_addr", mem_addr, 32'h200);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("dr2.mem_req", 32'(mem_req), 32'd0);
        chk("dr2.mem_addr", mem_addr, 32'd0);
        dispatch();
        chk("postsq.tail", 32'(sq_tail), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
